led_pwm_fader: RTL and testbench
================================

Name: led_pwm_fader

Overview:
- Downstream stage between the attosoc 8-bit `soc_led` bus and the 12 board LED pins (4 RGB LEDs).
- Replaces the direct combinational bit mapping with per-channel PWM, one global brightness level, and linear fade-in/fade-out so LED changes ramp instead of snapping.
- Runs in the SoC clock domain (50 MHz buffered clock).

Parameters:
PRESCALE, 195, clk cycles per PWM counter step (50 MHz / 195 / 256 ≈ 1 kHz PWM frame)
PWM_BITS, 8, width of the PWM counter, duties and level
FADE_DIV, 4, PWM frames per fade step (±1 duty LSB per step)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
led_in  in  8  SoC LED bits; 2 bits per RGB LED
level  in  PWM_BITS  global brightness applied to every lit channel
led_out  out  12  pins: [3:0] R, [7:4] G, [11:8] B
frame_tick  out  1  one-cycle pulse at the start of every PWM frame

Behaviour:
- Reset is asynchronous and active-low.
  - While `resetn` = 0: all counters, duties and outputs are 0; `led_out` = 12'h000; `frame_tick` = 0.
  - Reset deassertion mid-frame restarts cleanly at prescaler = 0, counter = 0.
- Channel mapping, i = 0..3, evaluated on the registered `led_in`:
  - on_R[i] = b[2i]
  - on_G[i] = b[2i+1]
  - on_B[i] = b[2i] & b[2i+1]
- Prescaler counts 0..PRESCALE-1 and wraps. The PWM counter `pcnt` increments on each prescaler wrap and wraps 2^PWM_BITS-1 → 0.
- `frame_tick` = 1 for exactly the one clk cycle in which `pcnt` wraps to 0.
- Per channel:
  - target = on ? `level` : 0.
  - `cur` is a PWM_BITS register that steps once per fade step. A fade step occurs on every FADE_DIV-th `frame_tick`, from a frame counter 0..FADE_DIV-1.
  - At each fade step: cur < target → cur+1; cur > target → cur−1; equal → hold. Saturating; never wraps.
- Duty latching:
  - `duty` = `cur`, sampled only on `frame_tick`, so duty changes are glitch-free mid-frame.
  - `led_out` bit is registered: 1 when duty == all-ones (100%), else (`pcnt` < duty).
  - duty 0 → constantly low.
- Latency:
  - `led_in`/`level` change → first visible duty change = 1 input register stage + up to FADE_DIV frames.
  - Full ramp 0 → 255 = 255 × FADE_DIV frames.
- Simultaneous events:
  - A target change on the same cycle as a fade step uses the new target.
  - A `level` change mid-fade redirects the ramp without a jump.
- `led_in`/`level` are sampled every clk; no handshake. Inputs are synchronous to `clk`.

Decomposition:
- Package `led_pwm_pkg`:
  - PWM_BITS default
  - LED count (4) and channel count (12)
  - channel index constants R_BASE = 0, G_BASE = 4, B_BASE = 8
- Sub-module `pwm_fade_channel`, instantiated 12× by generate:
  - inputs: clk, resetn, target, fade_step, frame_tick, pcnt
  - output: pin
- The top holds the shared prescaler, `pcnt`, frame counter and mapping logic.

Test Plan:
1. Reset with `resetn` = 0 for 10 cycles, `led_in` = 8'hFF, `level` = 8'hFF → `led_out` = 0 throughout; after release, `frame_tick` first pulses 195×256 cycles later.
2. PRESCALE = 1, FADE_DIV = 1, `led_in` = 8'h01, `level` = 8'h80 → R0 `cur` reaches 128 after 128 frames, then steady high 128/256 cycles per frame; G0/B0 stay 0.
3. `led_in` = 8'h03, `level` = 8'hFF, fully faded → R0, G0, B0 constantly 1 (100% duty, no 1-cycle low gap).
4. From steady duty 200, drop `led_in` to 0 → duty decrements 1 per FADE_DIV frames, reaching 0 after 200×FADE_DIV frames; no wrap below 0.
5. Change `level` 0x40 → 0x20 mid-frame while ramping up at 0x30 → `cur` reverses to decrement next step; `led_out` duty within the current frame unchanged.
6. Assert `resetn` low mid-frame with outputs active → `led_out` = 0 asynchronously (before next clk edge); all duties restart from 0.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the LED PWM fader: channel layout and fade direction.
package led_pwm_pkg;

   localparam int PWM_BITS_DEF = 8;
   localparam int NUM_LEDS     = 4;
   localparam int NUM_CH       = 3 * NUM_LEDS;
   localparam int R_BASE       = 0;
   localparam int G_BASE       = 4;
   localparam int B_BASE       = 8;

   typedef enum logic [1:0] {
      FADE_HOLD = 2'd0,
      FADE_UP   = 2'd1,
      FADE_DOWN = 2'd2
   } fade_dir_e;

   // Counter width that stays legal when the modulus is 1.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// One LED channel: linear fade of the current duty toward a target, frame-latched
// duty, and a registered PWM comparator output.
module pwm_fade_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEF
)
(
   input  logic                clk,
   input  logic                resetn,
   input  logic [PWM_BITS-1:0] target,
   input  logic                fade_step,
   input  logic                frame_tick,
   input  logic [PWM_BITS-1:0] pcnt,
   output logic                pin
);

   logic [PWM_BITS-1:0] cur_q, cur_d;
   logic [PWM_BITS-1:0] duty_q;
   logic                pin_q, pin_d;
   fade_dir_e           dir;

   always_comb begin
      dir = FADE_HOLD;
      if (cur_q < target) begin
         dir = FADE_UP;
      end else if (cur_q > target) begin
         dir = FADE_DOWN;
      end
   end

   // Stepping only toward the target means cur can never wrap at either end.
   always_comb begin
      cur_d = cur_q;
      if (fade_step) begin
         case (dir)
            FADE_UP:   cur_d = cur_q + PWM_BITS'(1);
            FADE_DOWN: cur_d = cur_q - PWM_BITS'(1);
            default:   cur_d = cur_q;
         endcase
      end
   end

   assign pin_d = (&duty_q) | (pcnt < duty_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cur_q  <= '0;
         duty_q <= '0;
         pin_q  <= 1'b0;
      end else begin
         cur_q <= cur_d;
         if (frame_tick) begin
            duty_q <= cur_q;
         end
         pin_q <= pin_d;
      end
   end

   assign pin = pin_q;

endmodule

// File: rtl/led_pwm_fader.sv
// Maps the SoC LED byte onto 12 RGB pins through per-channel PWM with a global
// brightness level and linear fading. Holds the shared prescaler, PWM and frame counters.
module led_pwm_fader
   import led_pwm_pkg::*;
#(
   parameter int PRESCALE = 195,
   parameter int PWM_BITS = PWM_BITS_DEF,
   parameter int FADE_DIV = 4
)
(
   input  logic                clk,
   input  logic                resetn,
   input  logic [7:0]          led_in,
   input  logic [PWM_BITS-1:0] level,
   output logic [11:0]         led_out,
   output logic                frame_tick
);

   localparam int PSC_W = clog2_min1(PRESCALE);
   localparam int FD_W  = clog2_min1(FADE_DIV);

   logic [7:0]          led_in_q;
   logic [PWM_BITS-1:0] level_q;
   logic [PSC_W-1:0]    psc_q, psc_d;
   logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
   logic [FD_W-1:0]     fdiv_q, fdiv_d;
   logic                frame_tick_q;
   logic                psc_wrap, frame_wrap, fade_step;
   logic [NUM_CH-1:0]   on_vec;
   logic [NUM_CH-1:0]   pin_vec;

   assign psc_wrap   = (psc_q == PSC_W'(PRESCALE - 1));
   assign frame_wrap = psc_wrap & (&pcnt_q);
   assign fade_step  = frame_wrap & (fdiv_q == FD_W'(FADE_DIV - 1));

   always_comb begin
      psc_d  = psc_wrap ? '0 : psc_q + PSC_W'(1);
      pcnt_d = psc_wrap ? pcnt_q + PWM_BITS'(1) : pcnt_q;
      fdiv_d = fdiv_q;
      if (frame_wrap) begin
         fdiv_d = (fdiv_q == FD_W'(FADE_DIV - 1)) ? '0 : fdiv_q + FD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_in_q     <= '0;
         level_q      <= '0;
         psc_q        <= '0;
         pcnt_q       <= '0;
         fdiv_q       <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         led_in_q     <= led_in;
         level_q      <= level;
         psc_q        <= psc_d;
         pcnt_q       <= pcnt_d;
         fdiv_q       <= fdiv_d;
         frame_tick_q <= frame_wrap;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEDS; gi++) begin : g_map
         assign on_vec[R_BASE+gi] = led_in_q[2*gi];
         assign on_vec[G_BASE+gi] = led_in_q[2*gi+1];
         assign on_vec[B_BASE+gi] = led_in_q[2*gi] & led_in_q[2*gi+1];
      end

      // Channels get the wrap strobe a cycle before frame_tick so the new duty
      // lands together with pcnt = 0 and every frame uses a single duty.
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [PWM_BITS-1:0] target;
         assign target = on_vec[gi] ? level_q : '0;

         pwm_fade_channel #(
            .PWM_BITS (PWM_BITS)
         ) u_ch (
            .clk        (clk),
            .resetn     (resetn),
            .target     (target),
            .fade_step  (fade_step),
            .frame_tick (frame_wrap),
            .pcnt       (pcnt_q),
            .pin        (pin_vec[gi])
         );
      end
   endgenerate

   assign led_out    = pin_vec;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PRESCALE=2, PWM_BITS=4, FADE_DIV=2 (32-cycle frames).
module tb_led_pwm_fader;

   localparam int FRAME = 32;

   logic        clk;
   logic        resetn;
   logic [7:0]  led_in;
   logic [3:0]  level;
   logic [11:0] led_out;
   logic        frame_tick;

   int errors = 0;
   int checks = 0;
   int cnt [12];

   led_pwm_fader #(
      .PRESCALE (2),
      .PWM_BITS (4),
      .FADE_DIV (2)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .led_in     (led_in),
      .level      (level),
      .led_out    (led_out),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Measures high cycles per pin over the frame whose tick is visible now (or next).
   task automatic measure(input string tag, input int chg_at, input logic [3:0] chg_lvl);
      int got;
      int tk;
      got = 0;
      for (int n = 0; n < 100; n++) begin
         if (frame_tick) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_tick_wait"}, got, 1);
      for (int i = 0; i < 12; i++) cnt[i] = 0;
      tk = 0;
      for (int c = 0; c < FRAME; c++) begin
         @(negedge clk);
         if (c == chg_at) level = chg_lvl;
         for (int i = 0; i < 12; i++) begin
            if (led_out[i[3:0]]) cnt[i]++;
         end
         if (frame_tick) tk++;
      end
      chk({tag, "_tick_count"}, tk, 1);
      $display("frame %s: r0=%0d g0=%0d b0=%0d r1=%0d", tag, cnt[0], cnt[4], cnt[8], cnt[1]);
   endtask

   task automatic check_frame(input string tag, input int er0, input int eg0,
                              input int eb0, input int eo);
      int e;
      for (int i = 0; i < 12; i++) begin
         e = (i == 0) ? er0 : (i == 4) ? eg0 : (i == 8) ? eb0 : eo;
         chk($sformatf("%s_ch%0d", tag, i), cnt[i], e);
      end
   endtask

   task automatic skip(input int frames);
      repeat (frames * FRAME) @(negedge clk);
   endtask

   task automatic first_tick(input string tag);
      int first;
      first = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (frame_tick) begin
            first = c;
            break;
         end
      end
      chk(tag, first, FRAME);
   endtask

   initial begin
      resetn = 1'b0;
      led_in = 8'hFF;
      level  = 4'hF;

      // Reset held: outputs quiet.
      repeat (10) begin
         @(negedge clk);
         chk("rst_led_out", int'(led_out), 0);
         chk("rst_frame_tick", int'(frame_tick), 0);
      end
      resetn = 1'b1;
      first_tick("first_tick_after_reset");
      chk("led_out_frame1_start", int'(led_out), 0);

      // Ramp up all channels to full scale.
      measure("f1", -1, 4'h0);  check_frame("f1", 0, 0, 0, 0);
      measure("f2", -1, 4'h0);  check_frame("f2", 0, 0, 0, 0);
      measure("f3", -1, 4'h0);  check_frame("f3", 2, 2, 2, 2);
      measure("f4", -1, 4'h0);  check_frame("f4", 2, 2, 2, 2);
      measure("f5", -1, 4'h0);  check_frame("f5", 4, 4, 4, 4);
      skip(24);
      measure("f30", -1, 4'h0); check_frame("f30", 28, 28, 28, 28);
      measure("f31", -1, 4'h0); check_frame("f31", 32, 32, 32, 32);
      chk("full_duty_at_boundary", int'(led_out), 12'hFFF);

      // Only R0 lit at half level; everything else fades to zero.
      led_in = 8'h01;
      level  = 4'h8;
      skip(15);
      measure("f47", -1, 4'h0); check_frame("f47", 16, 16, 16, 16);
      skip(1);
      measure("f49", -1, 4'h0); check_frame("f49", 16, 14, 14, 14);
      skip(13);
      measure("f63", -1, 4'h0); check_frame("f63", 16, 0, 0, 0);
      skip(1);
      measure("f65", -1, 4'h0); check_frame("f65", 16, 0, 0, 0);

      // Ramp R0/G0/B0 toward 12, then redirect to 3 mid-frame.
      led_in = 8'h03;
      level  = 4'hC;
      measure("f66", -1, 4'h0); check_frame("f66", 16, 0, 0, 0);
      skip(11);
      measure("f78", 9, 4'h3);  check_frame("f78", 24, 10, 10, 0);
      measure("f79", -1, 4'h0); check_frame("f79", 24, 12, 12, 0);
      measure("f80", -1, 4'h0); check_frame("f80", 24, 12, 12, 0);
      measure("f81", -1, 4'h0); check_frame("f81", 22, 10, 10, 0);

      // Asynchronous reset while pins are driving high.
      repeat (5) @(negedge clk);
      chk("active_before_reset", int'(led_out), 12'h111);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_led_out", int'(led_out), 0);
      chk("async_rst_frame_tick", int'(frame_tick), 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      first_tick("first_tick_after_rerst");
      measure("r1", -1, 4'h0);  check_frame("r1", 0, 0, 0, 0);
      skip(1);
      measure("r3", -1, 4'h0);  check_frame("r3", 2, 2, 2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
